// File: rtl/ddr4_app_requester.sv
// Job-driven initiator for the DDR4 app_* interface: one descriptor at a time.
// Writes stream straight through to app_wdf_*; reads are credit-limited into a return FIFO.
module ddr4_app_requester #(
  parameter int DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH  = 28,
  parameter int LEN_WIDTH   = 16,
  parameter int ADDR_STRIDE = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                    ui_clk,
  input  logic                    ui_rst,
  input  logic                    init_calib_complete,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic                    job_write,
  input  logic [ADDR_WIDTH-1:0]   job_addr,
  input  logic [LEN_WIDTH-1:0]    job_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  input  logic                    app_rdy,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]   app_rd_data,
  input  logic                    app_rd_data_valid,
  input  logic                    app_rd_data_end
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_RUN = 3'd1,
    ST_RD_RUN = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   cur_addr_r;
  logic [LEN_WIDTH-1:0]    remaining_r;
  logic [LEN_WIDTH-1:0]    len_r;
  logic [LEN_WIDTH-1:0]    returned_r;
  logic [CNT_W-1:0]        outstanding_r;
  logic [CNT_W-1:0]        fifo_count_r;
  logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
  logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic                    err_r;

  logic                    job_accept_s, wr_beat_s, rd_req_s, rd_fire_s;
  logic                    rd_push_s, rd_pop_s, credit_ok_s;
  logic [SUM_W-1:0]        credit_sum_s;
  logic                    unused_s;

  assign job_ready    = (state_r == ST_IDLE) & init_calib_complete & ~ui_rst;
  assign job_accept_s = job_valid & job_ready;
  assign wr_beat_s    = (state_r == ST_WR_RUN) & wr_valid & app_rdy & app_wdf_rdy;

  // Credits cover both in-flight reads and words still parked in the FIFO.
  assign credit_sum_s = SUM_W'(outstanding_r) + SUM_W'(fifo_count_r);
  assign credit_ok_s  = credit_sum_s < SUM_W'(FIFO_DEPTH);
  assign rd_req_s     = (state_r == ST_RD_RUN) & (remaining_r != '0) & credit_ok_s;
  assign rd_fire_s    = rd_req_s & app_rdy;
  assign rd_push_s    = app_rd_data_valid & (outstanding_r != '0);
  assign rd_pop_s     = rd_valid & rd_ready;

  assign busy         = (state_r != ST_IDLE);
  assign err          = err_r;
  assign app_addr     = cur_addr_r;
  assign app_wdf_data = wr_data;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;
  assign rd_valid     = (fifo_count_r != '0);
  assign rd_data      = rd_valid ? mem_r[rd_ptr_r] : '0;
  assign unused_s     = app_rd_data_end;

  // Next-state decode and per-state command/handshake outputs.
  always_comb begin
    state_s      = state_r;
    app_en       = 1'b0;
    app_cmd      = 3'b000;
    app_wdf_wren = 1'b0;
    wr_ready     = 1'b0;
    done         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (job_accept_s) begin
          if (job_len == '0) begin
            state_s = ST_DONE;
          end else begin
            state_s = job_write ? ST_WR_RUN : ST_RD_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR_RUN: begin
        app_en       = wr_beat_s;
        app_wdf_wren = wr_beat_s;
        wr_ready     = wr_beat_s;
        if (wr_beat_s && (remaining_r == LEN_WIDTH'(1))) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WR_RUN;
        end
      end
      ST_RD_RUN: begin
        app_en  = rd_req_s;
        app_cmd = 3'b001;
        if (rd_fire_s && (remaining_r == LEN_WIDTH'(1))) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RD_RUN;
        end
      end
      ST_DRAIN: begin
        // Look at this cycle's return so done follows the last word by one cycle.
        if ((returned_r + LEN_WIDTH'(rd_push_s)) == len_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Job bookkeeping, credit counters, FIFO pointers and sticky error.
  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      state_r       <= ST_IDLE;
      cur_addr_r    <= '0;
      remaining_r   <= '0;
      len_r         <= '0;
      returned_r    <= '0;
      outstanding_r <= '0;
      fifo_count_r  <= '0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      err_r         <= 1'b0;
    end else begin
      state_r <= state_s;
      if (job_accept_s) begin
        cur_addr_r  <= job_addr;
        remaining_r <= job_len;
        len_r       <= job_len;
      end else if (wr_beat_s || rd_fire_s) begin
        cur_addr_r  <= cur_addr_r + ADDR_WIDTH'(ADDR_STRIDE);
        remaining_r <= remaining_r - LEN_WIDTH'(1);
      end
      if (job_accept_s) begin
        returned_r <= '0;
      end else if (rd_push_s) begin
        returned_r <= returned_r + LEN_WIDTH'(1);
      end
      case ({rd_fire_s, rd_push_s})
        2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
      case ({rd_push_s, rd_pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1);
        2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1);
        default: fifo_count_r <= fifo_count_r;
      endcase
      if (rd_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (app_rd_data_valid && (outstanding_r == '0)) begin
        err_r <= 1'b1;
      end
    end
  end

  // Return FIFO storage; contents are don't-care until the count covers them.
  always_ff @(posedge ui_clk) begin
    if (rd_push_s) begin
      mem_r[wr_ptr_r] <= app_rd_data;
    end
  end

endmodule

// File: tb/tb_ddr4_app_requester.sv
// Self-checking bench for ddr4_app_requester: directed plan items, then randomized jobs
// compared against an address/data model computed from job descriptors.
module tb_ddr4_app_requester;

  localparam int DW = 512;
  localparam int AW = 28;
  localparam int LW = 16;

  typedef struct { logic [AW-1:0] addr; logic [2:0] cmd; int cyc; } fire_t;
  typedef struct { int due; logic [AW-1:0] addr; } resp_t;

  logic ui_clk = 1'b0;
  logic ui_rst, init_calib_complete;
  logic job_valid, job_ready, job_write;
  logic [AW-1:0] job_addr;
  logic [LW-1:0] job_len;
  logic busy, done, err;
  logic [DW-1:0] wr_data, rd_data, app_wdf_data, app_rd_data;
  logic wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] app_addr;
  logic [2:0] app_cmd;
  logic app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DW/8-1:0] app_wdf_mask;
  logic app_rd_data_valid, app_rd_data_end;

  logic resp_valid, spur_valid;
  logic [DW-1:0] resp_data, spur_data;
  logic rand_mode, fix_app_rdy, fix_wdf_rdy, fix_rd_ready;
  int fix_lat;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int src_idx = 0;
  int incoh_cnt = 0;
  int bad_wr_en = 0;
  int last_due = 0;
  int resp_idx = 0;

  fire_t fire_q[$];
  resp_t resp_q[$];
  logic [DW-1:0] wdata_q[$];
  logic [DW-1:0] rdout_q[$];
  int ret_cyc_q[$];
  int done_cyc_q[$];
  int acc_cyc_q[$];

  assign app_rd_data_valid = resp_valid | spur_valid;
  assign app_rd_data       = resp_valid ? resp_data : spur_data;
  assign app_rd_data_end   = app_rd_data_valid;

  ddr4_app_requester dut (
    .ui_clk(ui_clk), .ui_rst(ui_rst), .init_calib_complete(init_calib_complete),
    .job_valid(job_valid), .job_ready(job_ready), .job_write(job_write),
    .job_addr(job_addr), .job_len(job_len),
    .busy(busy), .done(done), .err(err),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end)
  );

  always #5 ui_clk = ~ui_clk;

  always @(posedge ui_clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input int k);
    logic [DW-1:0] v;
    for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = 32'(k) * 32'h0100_0193 + 32'(j) + 32'h1000_0000;
    return v;
  endfunction

  function automatic logic [DW-1:0] rdpat(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = {4'(j), a};
    return v;
  endfunction

  // Upstream write source and controller readiness (random or fixed levels).
  initial begin
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; rd_ready = 1'b1; wr_valid = 1'b0; wr_data = '0;
    forever begin
      @(posedge ui_clk); #2;
      app_rdy     = rand_mode ? ($urandom_range(0, 3) != 0) : fix_app_rdy;
      app_wdf_rdy = rand_mode ? ($urandom_range(0, 3) != 0) : fix_wdf_rdy;
      rd_ready    = rand_mode ? ($urandom_range(0, 2) != 0) : fix_rd_ready;
      wr_valid    = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_data     = pat(src_idx);
    end
  end

  // Controller read-return model: in order, one word per cycle, at the scheduled cycle.
  initial begin
    resp_valid = 1'b0; resp_data = '0;
    forever begin
      @(posedge ui_clk); #2;
      if (resp_idx < resp_q.size() && resp_q[resp_idx].due <= cyc) begin
        resp_valid = 1'b1;
        resp_data  = rdpat(resp_q[resp_idx].addr);
        resp_idx++;
      end else begin
        resp_valid = 1'b0;
      end
    end
  end

  // Passive monitor: records every transfer, settled, at the falling edge.
  initial begin
    int due;
    forever begin
      @(negedge ui_clk);
      if (app_en && app_rdy) begin
        fire_q.push_back('{app_addr, app_cmd, cyc});
        if (app_cmd == 3'b001) begin
          due = cyc + (rand_mode ? $urandom_range(1, 25) : fix_lat);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          resp_q.push_back('{due, app_addr});
        end
      end
      if (app_wdf_wren && app_wdf_rdy) wdata_q.push_back(app_wdf_data);
      if (wr_valid && wr_ready) src_idx++;
      if (rd_valid && rd_ready) rdout_q.push_back(rd_data);
      if (app_rd_data_valid) ret_cyc_q.push_back(cyc);
      if (done) done_cyc_q.push_back(cyc);
      if (job_valid && job_ready) acc_cyc_q.push_back(cyc);
      if (app_cmd == 3'b000 && (app_en != app_wdf_wren || app_en != wr_ready)) incoh_cnt++;
      if (app_wdf_end != app_wdf_wren) incoh_cnt++;
      if (app_en && app_cmd == 3'b000 && !(wr_valid && app_rdy && app_wdf_rdy)) bad_wr_en++;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge ui_clk); #1;
  endtask

  task automatic drive();
    @(posedge ui_clk); #1;
  endtask

  task automatic do_job(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] n);
    int k;
    drive();
    job_valid = 1'b1; job_write = w; job_addr = a; job_len = n;
    k = 0;
    tick();
    while (!job_ready && k < 200) begin tick(); k++; end
    chk("job_accept", job_ready, 1);
    drive();
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int k;
    k = 0;
    while (done_cyc_q.size() <= base && k < budget) begin tick(); k++; end
    chk("done_seen", (done_cyc_q.size() > base) ? 1 : 0, 1);
  endtask

  // Reference: beat i goes to start + i*stride mod 2^AW; data follows the stream order.
  task automatic check_job(input logic w, input logic [AW-1:0] a, input int n,
                           input int fb, input int wb, input int rb, input int db);
    logic [AW-1:0] ea;
    chk("fire_count", fire_q.size() - fb, n);
    for (int i = 0; i < n; i++) begin
      ea = a + AW'(8 * i);
      if (fb + i < fire_q.size()) begin
        chk("app_addr", fire_q[fb + i].addr, ea);
        chk("app_cmd", fire_q[fb + i].cmd, w ? 3'b000 : 3'b001);
      end
      if (w && (wb + i < wdata_q.size())) chk("wr_beat_data", wdata_q[wb + i], pat(wb + i));
      if (!w) begin
        chk("rd_present", (rb + i < rdout_q.size()) ? 1 : 0, 1);
        if (rb + i < rdout_q.size()) chk("rd_beat_data", rdout_q[rb + i], rdpat(ea));
      end
    end
    if (w) chk("wr_beat_count", wdata_q.size() - wb, n);
    chk("done_once", done_cyc_q.size() - db, 1);
  endtask

  initial begin
    int fb, wb, rb, db, retb, t, k, n, inc0, bad0;
    logic w;
    logic [AW-1:0] a;
    ui_rst = 1'b1; init_calib_complete = 1'b0;
    job_valid = 1'b0; job_write = 1'b0; job_addr = '0; job_len = '0;
    spur_valid = 1'b0; spur_data = '0;
    rand_mode = 1'b0; fix_app_rdy = 1'b1; fix_wdf_rdy = 1'b1; fix_rd_ready = 1'b1; fix_lat = 20;

    // Reset values
    repeat (3) drive();
    tick();
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_err", err, 0);         chk("rst_rd_valid", rd_valid, 0);
    chk("rst_app_en", app_en, 0);   chk("rst_wren", app_wdf_wren, 0);
    chk("rst_wr_ready", wr_ready, 0); chk("rst_app_addr", app_addr, 0);
    chk("rst_app_cmd", app_cmd, 0); chk("rst_rd_data", rd_data, 0);
    chk("rst_job_ready", job_ready, 0); chk("wdf_mask", app_wdf_mask, 0);
    drive(); ui_rst = 1'b0;
    tick(); chk("ready_no_calib", job_ready, 0);
    drive(); init_calib_complete = 1'b1;
    tick(); chk("ready_calib", job_ready, 1);

    // Zero-stall write, 4 beats
    inc0 = incoh_cnt; bad0 = bad_wr_en;
    fb = fire_q.size(); wb = wdata_q.size(); db = done_cyc_q.size();
    do_job(1'b1, 28'h0000100, 16'd4);
    wait_done(db, 50);
    t = acc_cyc_q[$];
    chk("wr_done_ready", job_ready, 0);
    tick(); chk("wr_ready_again", job_ready, 1);
    check_job(1'b1, 28'h0000100, 4, fb, wb, 0, db);
    if (done_cyc_q.size() > db) chk("wr_done_latency", done_cyc_q[db] - t, 5);
    for (int i = 0; i < 4; i++)
      if (fb + i < fire_q.size()) chk("wr_beat_cycle", fire_q[fb + i].cyc - t, i + 1);

    // Write with app_wdf_rdy low for 3 cycles mid-job
    fb = fire_q.size(); wb = wdata_q.size(); db = done_cyc_q.size();
    do_job(1'b1, 28'h0002000, 16'd6);
    drive(); fix_wdf_rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_app_en", app_en, 0);
      chk("stall_wren", app_wdf_wren, 0);
      chk("stall_wr_ready", wr_ready, 0);
      drive();
    end
    fix_wdf_rdy = 1'b1;
    wait_done(db, 50);
    check_job(1'b1, 28'h0002000, 6, fb, wb, 0, db);
    chk("wr_coherence", incoh_cnt - inc0, 0);
    chk("wr_en_gating", bad_wr_en - bad0, 0);

    // Read 32 with sink stalled: credits stop at 16
    fb = fire_q.size(); rb = rdout_q.size(); db = done_cyc_q.size(); retb = ret_cyc_q.size();
    drive(); fix_rd_ready = 1'b0; fix_lat = 20;
    do_job(1'b0, 28'h0040000, 16'd32);
    k = 0;
    while (!app_rd_data_valid && k < 60) begin tick(); k++; end
    chk("first_return_seen", app_rd_data_valid, 1);
    chk("rd_valid_before", rd_valid, 0);
    tick(); chk("rd_valid_after", rd_valid, 1);
    repeat (60) tick();
    chk("credit_fires", fire_q.size() - fb, 16);
    chk("credit_returns", ret_cyc_q.size() - retb, 16);
    chk("credit_rd_valid", rd_valid, 1);
    chk("credit_no_pop", rdout_q.size() - rb, 0);
    drive(); fix_rd_ready = 1'b1;
    wait_done(db, 300);
    repeat (5) tick();
    check_job(1'b0, 28'h0040000, 32, fb, 0, rb, db);
    if (done_cyc_q.size() > db && ret_cyc_q.size() > retb)
      chk("rd_done_after_last", done_cyc_q[db] - ret_cyc_q[$], 1);
    chk("rd_err_clear", err, 0);
    chk("rd_fifo_empty", rd_valid, 0);

    // Address wrap
    fb = fire_q.size(); wb = wdata_q.size(); db = done_cyc_q.size();
    do_job(1'b1, 28'hFFFFFF8, 16'd2);
    wait_done(db, 50);
    check_job(1'b1, 28'hFFFFFF8, 2, fb, wb, 0, db);
    if (fb + 1 < fire_q.size()) chk("wrap_zero", fire_q[fb + 1].addr, 28'h0000000);

    // Zero-length job, then a spurious return while idle
    fb = fire_q.size(); db = done_cyc_q.size();
    do_job(1'b1, 28'h0000123, 16'd0);
    wait_done(db, 20);
    check_job(1'b1, 28'h0000123, 0, fb, wdata_q.size(), 0, db);
    if (done_cyc_q.size() > db) chk("len0_done_latency", done_cyc_q[db] - acc_cyc_q[$], 1);
    chk("len0_err_before", err, 0);
    drive(); spur_valid = 1'b1; spur_data = rdpat(28'h1234567);
    drive(); spur_valid = 1'b0;
    tick();
    chk("spurious_err", err, 1);
    chk("spurious_fifo", rd_valid, 0);

    // Reset during a read with 5 outstanding
    fb = fire_q.size();
    fix_lat = 30;
    do_job(1'b0, 28'h0300000, 16'd20);
    repeat (5) drive();
    fix_app_rdy = 1'b0; ui_rst = 1'b1;
    tick();
    drive();
    tick();
    chk("mid_fires", fire_q.size() - fb, 5);
    chk("mid_busy", busy, 0);       chk("mid_done", done, 0);
    chk("mid_err", err, 0);         chk("mid_rd_valid", rd_valid, 0);
    chk("mid_app_en", app_en, 0);   chk("mid_wren", app_wdf_wren, 0);
    chk("mid_wr_ready", wr_ready, 0); chk("mid_app_addr", app_addr, 0);
    chk("mid_app_cmd", app_cmd, 0); chk("mid_rd_data", rd_data, 0);
    chk("mid_job_ready", job_ready, 0);
    drive(); ui_rst = 1'b0; fix_app_rdy = 1'b1;
    tick(); chk("post_rst_ready", job_ready, 1);
    repeat (40) tick();
    chk("late_return_err", err, 1);
    chk("late_return_fifo", rd_valid, 0);
    drive(); ui_rst = 1'b1;
    drive(); ui_rst = 1'b0;
    tick(); chk("err_cleared", err, 0);

    // Randomized jobs with random readiness and return latency
    inc0 = incoh_cnt; bad0 = bad_wr_en;
    drive(); rand_mode = 1'b1;
    for (int j = 0; j < 8; j++) begin
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom);
      n = $urandom_range(1, 40);
      fb = fire_q.size(); wb = wdata_q.size(); rb = rdout_q.size(); db = done_cyc_q.size();
      do_job(w, a, LW'(n));
      wait_done(db, 2000);
      k = 0;
      while (!w && rdout_q.size() < rb + n && k < 500) begin tick(); k++; end
      check_job(w, a, n, fb, wb, rb, db);
    end
    chk("rand_err", err, 0);
    chk("rand_coherence", incoh_cnt - inc0, 0);
    chk("rand_en_gating", bad_wr_en - bad0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
